// File: rtl/sram_axi_pkg.sv
// Shared types and helpers for the SRAM-like to AXI3 bridge.
package sram_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_AR  = 3'd1,
    S_RD_R   = 3'd2,
    S_WR_AWW = 3'd3,
    S_WR_B   = 3'd4,
    S_DONE   = 3'd5
  } state_e;

  localparam int unsigned ID_INST = 0;
  localparam int unsigned ID_DATA = 1;

  localparam logic PORT_INST = 1'b0;
  localparam logic PORT_DATA = 1'b1;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  // Byte-lane strobe for a naturally aligned access of the given size.
  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << addr_lo;
      2'd1:    strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/sram_like_arbiter.sv
// Two-way request arbiter for the inst/data ports.
// SRAM_AXI_DATA_PRIO_EN: fixed data-over-inst priority; otherwise round-robin.
module sram_like_arbiter
  import sram_axi_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_inst_req,
  input  logic i_data_req,
  output logic o_gnt_inst_c,
  output logic o_gnt_data_c
);

  logic w_pick_data;

`ifdef SRAM_AXI_DATA_PRIO_EN
  assign w_pick_data = i_data_req;
`else
  logic r_last_grant;

  // On a tie the port that did not win last time goes first.
  assign w_pick_data = i_data_req & (~i_inst_req | (r_last_grant == PORT_INST));

  // Remember the most recent winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= PORT_INST;
    end else if (o_gnt_inst_c | o_gnt_data_c) begin
      r_last_grant <= o_gnt_data_c;
    end
  end
`endif

  assign o_gnt_data_c = i_en & w_pick_data;
  assign o_gnt_inst_c = i_en & i_inst_req & ~w_pick_data;

endmodule

// File: rtl/sram_like_axi_bridge.sv
// SRAM-like inst/data slave ports to a single-outstanding AXI3 master.
// Config macro: SRAM_AXI_DATA_PRIO_EN (fixed data priority instead of round-robin).
module sram_like_axi_bridge
  import sram_axi_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [3:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic [1:0]        arlock,
  output logic [3:0]        arcache,
  output logic [2:0]        arprot,
  output logic              arvalid,
  input  logic              arready,
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic [ID_W-1:0]   awid,
  output logic [ADDR_W-1:0] awaddr,
  output logic [3:0]        awlen,
  output logic [2:0]        awsize,
  output logic [1:0]        awburst,
  output logic [1:0]        awlock,
  output logic [3:0]        awcache,
  output logic [2:0]        awprot,
  output logic              awvalid,
  input  logic              awready,
  output logic [ID_W-1:0]   wid,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic              wlast,
  output logic              wvalid,
  input  logic              wready,
  input  logic [ID_W-1:0]   bid,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e            r_state;
  state_e            w_next;
  logic              r_port;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_aw_done;
  logic              r_w_done;

  logic w_gnt_inst;
  logic w_gnt_data;
  logic w_gnt;
  logic w_sel_wr;
  logic w_unused;

  // Responses carry nothing we need with a single transaction in flight.
  assign w_unused = ^{rid, rresp, rlast, bid, bresp};

  sram_like_arbiter u_arb (
    .clk          (clk),
    .rst          (rst),
    .i_en         (r_state == S_IDLE),
    .i_inst_req   (inst_req),
    .i_data_req   (data_req),
    .o_gnt_inst_c (w_gnt_inst),
    .o_gnt_data_c (w_gnt_data)
  );

  assign w_gnt        = w_gnt_inst | w_gnt_data;
  assign w_sel_wr     = w_gnt_data ? data_wr : inst_wr;
  assign inst_addr_ok = w_gnt_inst;
  assign data_addr_ok = w_gnt_data;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state and AXI handshake outputs.
  always_comb begin
    w_next  = r_state;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt) w_next = w_sel_wr ? S_WR_AWW : S_RD_AR;
      end
      S_RD_AR: begin
        arvalid = 1'b1;
        if (arready) w_next = S_RD_R;
      end
      S_RD_R: begin
        rready = 1'b1;
        if (rvalid) w_next = S_DONE;
      end
      S_WR_AWW: begin
        awvalid = ~r_aw_done;
        wvalid  = ~r_w_done;
        if ((r_aw_done | awready) && (r_w_done | wready)) w_next = S_WR_B;
      end
      S_WR_B: begin
        bready = 1'b1;
        if (bvalid) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch, read data capture and write-channel completion flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_port    <= PORT_INST;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_port    <= w_gnt_data;
            r_size    <= w_gnt_data ? data_size  : inst_size;
            r_addr    <= w_gnt_data ? data_addr  : inst_addr;
            r_wdata   <= w_gnt_data ? data_wdata : inst_wdata;
            r_rdata   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_RD_R: begin
          if (rvalid) r_rdata <= rdata;
        end
        S_WR_AWW: begin
          if (awvalid && awready) r_aw_done <= 1'b1;
          if (wvalid && wready)   r_w_done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign inst_data_ok = (r_state == S_DONE) && (r_port == PORT_INST);
  assign data_data_ok = (r_state == S_DONE) && (r_port == PORT_DATA);
  assign inst_rdata   = inst_data_ok ? r_rdata : '0;
  assign data_rdata   = data_data_ok ? r_rdata : '0;

  assign arid    = r_port ? ID_W'(ID_DATA) : ID_W'(ID_INST);
  assign araddr  = r_addr;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, r_size};
  assign arburst = AXI_BURST_INCR;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;

  assign awid    = arid;
  assign awaddr  = r_addr;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, r_size};
  assign awburst = AXI_BURST_INCR;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;

  assign wid   = awid;
  assign wdata = r_wdata;
  assign wstrb = STRB_W'(size_to_wstrb(r_size, r_addr[1:0]));
  assign wlast = 1'b1;

endmodule
